memory_responder: RTL and testbench

Memory-side responder for the CPU control unit's strobe protocol. It holds the memory address register (MAR), a RAM array, and a strobe-decoding state machine that serves reads (FETCH, GET, SHOW) and writes (PUT). It sits between the controller's MAR_load, CS, OE, WE, Bc and Ac lines and the datapath buses. It also flags protocol violations so a bench or debug port can detect sequencing errors.

---
 rtl/memory_responder.sv | 127 ++++++++++++
 tb/tb_memory_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Memory-side responder for the controller strobe protocol: holds the MAR,
// a reset-clearable RAM, and a CS/OE/WE decoder that serves reads and
// buffered writes while flagging illegal strobe sequences.
module memory_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MAR_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              CS,
  input  logic              OE,
  input  logic              WE,
  input  logic              Bc,
  input  logic              Ac,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              write_done,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEL   = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   data_q;
  logic                rd_seen;
  logic [DATA_W-1:0]   wbuf;
  logic                captured;
  logic                strobe_clash_c;
  logic                commit_c;
  logic                write_err_c;

  // Strobe decode: next state and protocol events from the sampled CS/OE/WE
  always_comb begin
    state_nxt      = S_IDLE;
    strobe_clash_c = 1'b0;
    if (!CS) begin
      if (!OE && WE) begin
        state_nxt = S_READ;
      end else if (!WE && OE) begin
        state_nxt = S_WRITE;
      end else begin
        state_nxt      = S_SEL;
        strobe_clash_c = !OE && !WE;
      end
    end
  end

  // A write only commits on a clean WE release with data captured; any other exit is an error
  always_comb begin
    commit_c    = 1'b0;
    write_err_c = 1'b0;
    if (state == S_WRITE) begin
      if (state_nxt == S_SEL) begin
        commit_c    = captured;
        write_err_c = !captured;
      end else if (state_nxt != S_WRITE) begin
        write_err_c = 1'b1;
      end
    end
  end

  // FSM, MAR, read/write buffers, RAM and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mar        <= '0;
      data_q     <= '0;
      rd_seen    <= 1'b0;
      wbuf       <= '0;
      captured   <= 1'b0;
      write_done <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);

      if (MAR_load && (state != S_READ) && (state != S_WRITE)) begin
        mar <= addr_in;
      end

      rd_seen <= (state_nxt == S_READ);
      if (state_nxt == S_READ) begin
        data_q <= mem[mar];
      end

      if (state_nxt == S_WRITE) begin
        if (Ac) begin
          wbuf     <= wdata;
          captured <= 1'b1;
        end
      end else begin
        captured <= 1'b0;
      end

      if (commit_c) begin
        mem[mar] <= wbuf;
      end
      write_done <= commit_c;

      if (strobe_clash_c || write_err_c) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Read data is gated straight by Bc so the bus releases within the cycle
  assign rdata_valid = (state == S_READ) && rd_seen && Bc;
  assign rdata       = rdata_valid ? data_q : '0;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: transaction-level reference
// model (word array + sticky error flag) driven by randomized traffic.
module tb_memory_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              MAR_load;
  logic [ADDR_W-1:0] addr_in;
  logic              CS, OE, WE, Bc, Ac;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              write_done;
  logic              busy;
  logic              proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model: what memory holds and whether an error has been seen
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_perr;

  memory_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MAR_load(MAR_load), .addr_in(addr_in),
    .CS(CS), .OE(OE), .WE(WE), .Bc(Bc), .Ac(Ac), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .write_done(write_done),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    ref_perr = 1'b0;
  endtask

  task automatic idle_inputs();
    MAR_load = 1'b0; addr_in = '0; CS = 1'b1; OE = 1'b1; WE = 1'b1;
    Bc = 1'b1; Ac = 1'b0; wdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // Full read transaction: load MAR, 2-cycle OE window, Bc drop probe, release
  task automatic do_read(input logic [ADDR_W-1:0] a,
                         output logic [DATA_W-1:0] d0, output logic v0,
                         output logic [DATA_W-1:0] d1, output logic v1,
                         output logic b1,
                         output logic [DATA_W-1:0] d_off, output logic v_off);
    MAR_load = 1'b1; addr_in = a; CS = 1'b1;
    tick();
    MAR_load = 1'b0; addr_in = ~a; CS = 1'b0; OE = 1'b0; WE = 1'b1; Bc = 1'b1;
    tick();
    d0 = rdata; v0 = rdata_valid;
    tick();
    d1 = rdata; v1 = rdata_valid; b1 = busy;
    Bc = 1'b0;
    #1;
    d_off = rdata; v_off = rdata_valid;
    Bc = 1'b1;
    OE = 1'b1;
    tick();
    CS = 1'b1;
    tick();
  endtask

  // Full write transaction: load MAR, 2 WE-low edges, release WE then CS
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic ac, output logic [3:0] wd_hist);
    MAR_load = 1'b1; addr_in = a; CS = 1'b1;
    tick();
    MAR_load = 1'b0; CS = 1'b0; OE = 1'b1; WE = 1'b0; Ac = ac; wdata = d;
    tick();
    wd_hist[0] = write_done;
    tick();
    wd_hist[1] = write_done;
    WE = 1'b1;
    tick();
    wd_hist[2] = write_done;
    CS = 1'b1; Ac = 1'b0;
    tick();
    wd_hist[3] = write_done;
    if (ac) ref_mem[a] = d;
    else    ref_perr = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rdata_valid); end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL reset_wd got %b exp 0", write_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", proto_err); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_after_reset();
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    do_read(4'd3, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (v0 !== 1'b1 || d0 !== 8'h00) begin errors++; $display("FAIL read0_cycle1 got v=%b d=%h exp v=1 d=00", v0, d0); end
    checks++; if (v1 !== 1'b1 || d1 !== 8'h00) begin errors++; $display("FAIL read0_cycle2 got v=%b d=%h exp v=1 d=00", v1, d1); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL read0_busy got %b exp 1", b1); end
    checks++; if (voff !== 1'b0 || doff !== 8'h00) begin errors++; $display("FAIL read0_bc_gate got v=%b d=%h exp v=0 d=00", voff, doff); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read0_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_put();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    do_write(4'd5, 8'hA7, 1'b1, wh);
    checks++; if (wh !== 4'b0100) begin errors++; $display("FAIL put_write_done got %b exp 0100", wh); end
    do_read(4'd5, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (v0 !== 1'b1 || d0 !== ref_mem[5]) begin errors++; $display("FAIL put_readback got v=%b d=%h exp v=1 d=%h", v0, d0, ref_mem[5]); end
    checks++; if (proto_err !== ref_perr) begin errors++; $display("FAIL put_perr got %b exp %b", proto_err, ref_perr); end
  endtask

  task automatic test_fetch_order();
    logic [3:0] wh;
    logic [DATA_W-1:0] d9;
    d9 = 8'($urandom_range(1, 255));
    do_write(4'd9, d9, 1'b1, wh);
    do_write(4'd15, ~d9, 1'b1, wh);
    CS = 1'b0; OE = 1'b1; WE = 1'b1; MAR_load = 1'b1; addr_in = 4'd9;
    tick();
    MAR_load = 1'b0; OE = 1'b0;
    tick();
    checks++; if (rdata !== ref_mem[9] || rdata_valid !== 1'b1) begin errors++; $display("FAIL fetch_first got v=%b d=%h exp v=1 d=%h", rdata_valid, rdata, ref_mem[9]); end
    addr_in = 4'd15; MAR_load = 1'b1;
    tick();
    checks++; if (rdata !== ref_mem[9]) begin errors++; $display("FAIL fetch_mar_frozen got %h exp %h", rdata, ref_mem[9]); end
    tick();
    checks++; if (rdata !== ref_mem[9]) begin errors++; $display("FAIL fetch_mar_frozen2 got %h exp %h", rdata, ref_mem[9]); end
    OE = 1'b1;
    tick();
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL fetch_oe_release got %b exp 0", rdata_valid); end
    MAR_load = 1'b0; CS = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    logic [ADDR_W-1:0] a;
    for (int n = 0; n < 24; n++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 8'($urandom), 1'b1, wh);
        checks++; if (wh !== 4'b0100) begin errors++; $display("FAIL rand_write_done[%0d] got %b exp 0100", n, wh); end
      end else begin
        do_read(a, d0, v0, d1, v1, b1, doff, voff);
        checks++; if (v0 !== 1'b1 || v1 !== 1'b1 || d0 !== ref_mem[a] || d1 !== ref_mem[a]) begin
          errors++; $display("FAIL rand_read[%0d] addr %0d got %h/%h v=%b%b exp %h", n, a, d0, d1, v0, v1, ref_mem[a]);
        end
        checks++; if (voff !== 1'b0 || doff !== 8'h00) begin errors++; $display("FAIL rand_bc_gate[%0d] got v=%b d=%h exp 0/00", n, voff, doff); end
      end
    end
    checks++; if (proto_err !== ref_perr) begin errors++; $display("FAIL rand_perr got %b exp %b", proto_err, ref_perr); end
  endtask

  task automatic test_abort();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    logic seen_wd;
    do_write(4'd7, 8'h5A, 1'b1, wh);
    MAR_load = 1'b1; addr_in = 4'd7; CS = 1'b1;
    tick();
    MAR_load = 1'b0; CS = 1'b0; OE = 1'b1; WE = 1'b0; Ac = 1'b1; wdata = 8'h3C;
    tick();
    seen_wd = write_done;
    CS = 1'b1;
    tick();
    seen_wd = seen_wd | write_done;
    ref_perr = 1'b1;
    WE = 1'b1; Ac = 1'b0;
    tick();
    seen_wd = seen_wd | write_done;
    checks++; if (proto_err !== ref_perr) begin errors++; $display("FAIL abort_perr got %b exp %b", proto_err, ref_perr); end
    checks++; if (seen_wd !== 1'b0) begin errors++; $display("FAIL abort_write_done got %b exp 0", seen_wd); end
    do_read(4'd7, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (d0 !== ref_mem[7]) begin errors++; $display("FAIL abort_mem got %h exp %h", d0, ref_mem[7]); end
  endtask

  task automatic test_no_capture();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    pulse_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL nocap_reset_perr got %b exp 0", proto_err); end
    do_write(4'd12, 8'hC3, 1'b1, wh);
    do_write(4'd12, 8'h99, 1'b0, wh);
    checks++; if (wh !== 4'b0000) begin errors++; $display("FAIL nocap_write_done got %b exp 0000", wh); end
    checks++; if (proto_err !== ref_perr) begin errors++; $display("FAIL nocap_perr got %b exp %b", proto_err, ref_perr); end
    do_read(4'd12, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (d0 !== ref_mem[12]) begin errors++; $display("FAIL nocap_mem got %h exp %h", d0, ref_mem[12]); end
  endtask

  task automatic test_both_low();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    logic seen_wd;
    pulse_reset();
    do_write(4'd4, 8'h42, 1'b1, wh);
    MAR_load = 1'b1; addr_in = 4'd4; CS = 1'b1;
    tick();
    MAR_load = 1'b0; CS = 1'b0; OE = 1'b0; WE = 1'b0; Ac = 1'b1; Bc = 1'b1; wdata = 8'hE1;
    tick();
    ref_perr = 1'b1;
    checks++; if (proto_err !== ref_perr) begin errors++; $display("FAIL clash_perr got %b exp %b", proto_err, ref_perr); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL clash_valid got %b exp 0", rdata_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clash_busy got %b exp 1", busy); end
    seen_wd = write_done;
    OE = 1'b1; WE = 1'b1;
    tick();
    seen_wd = seen_wd | write_done;
    CS = 1'b1; Ac = 1'b0;
    tick();
    seen_wd = seen_wd | write_done;
    checks++; if (seen_wd !== 1'b0) begin errors++; $display("FAIL clash_write_done got %b exp 0", seen_wd); end
    do_read(4'd4, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (d0 !== ref_mem[4]) begin errors++; $display("FAIL clash_mem got %h exp %h", d0, ref_mem[4]); end
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] wh;
    logic [DATA_W-1:0] d0, d1, doff;
    logic v0, v1, b1, voff;
    do_write(4'd2, 8'h11, 1'b1, wh);
    MAR_load = 1'b1; addr_in = 4'd2; CS = 1'b1;
    tick();
    MAR_load = 1'b0; CS = 1'b0; OE = 1'b1; WE = 1'b0; Ac = 1'b1; wdata = 8'h77;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midw_busy_before got %b exp 1", busy); end
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (busy !== 1'b0 || proto_err !== 1'b0 || write_done !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 8'h00) begin
      errors++; $display("FAIL midw_async_outputs got busy=%b perr=%b wd=%b v=%b d=%h exp all 0", busy, proto_err, write_done, rdata_valid, rdata);
    end
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    do_read(4'd2, d0, v0, d1, v1, b1, doff, voff);
    checks++; if (v0 !== 1'b1 || d0 !== ref_mem[2]) begin errors++; $display("FAIL midw_mem2 got v=%b d=%h exp v=1 d=%h", v0, d0, ref_mem[2]); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_put();
    test_fetch_order();
    test_random();
    test_abort();
    test_no_capture();
    test_both_low();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
